// File: rtl/dispatch_pkg.sv
// Shared status codes, FSM state type and defaults for the core dispatcher.
package dispatch_pkg;

  localparam int unsigned DEF_NUM_CORES = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_ACK   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/core_dispatcher_if.sv
// Sequencer/core-array bundle for core_dispatcher; slave = dispatcher side.
interface core_dispatcher_if
  import dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES = DEF_NUM_CORES,
  parameter int unsigned CNT_W     = 32
) ();

  logic                   start;
  logic [NUM_CORES-1:0]   core_mask;
  logic [NUM_CORES-1:0]   end_process;
  logic [2*NUM_CORES-1:0] status;
  logic                   busy;
  logic                   done;
  logic [NUM_CORES-1:0]   core_done;
  logic [CNT_W-1:0]       cycle_count;
  logic                   timeout;

  modport master (
    output start, core_mask, end_process,
    input  status, busy, done, core_done, cycle_count, timeout
  );

  modport slave (
    input  start, core_mask, end_process,
    output status, busy, done, core_done, cycle_count, timeout
  );

endinterface

// File: rtl/dispatch_slot.sv
// Per-core slot: latched mask bit, sticky finish bit and registered 2-bit status.
module dispatch_slot
  import dispatch_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       launch_i,
  input  logic       mask_i,
  input  logic       end_i,
  input  logic       run_i,
  input  logic       abort_i,
  input  state_e     state_d_i,
  output logic       mask_o,
  output logic       done_o,
  output logic       done_d_o,
  output logic [1:0] status_o
);

  logic       mask_q, mask_d;
  logic       done_q, done_d;
  logic [1:0] status_q, status_d;

  always_comb begin
    mask_d   = launch_i ? mask_i : mask_q;
    done_d   = done_q;
    if (launch_i)
      done_d = 1'b0;
    else if (run_i)
      done_d = done_q | (end_i & mask_q);

    // Status follows the state being entered so it is valid the cycle after the edge.
    status_d = ST_IDLE;
    unique case (state_d_i)
      S_RUN:   if (mask_d) status_d = ST_RUN;
      S_DONE:  if (mask_d) status_d = (abort_i && !done_d) ? ST_ABORT : ST_ACK;
      default: status_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_IDLE;
    end else begin
      mask_q   <= mask_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign mask_o   = mask_q;
  assign done_o   = done_q;
  assign done_d_o = done_d;
  assign status_o = status_q;

endmodule

// File: rtl/core_dispatcher.sv
// Launches masked cores, collects end_process, pulses done and counts RUN cycles.
// Optional watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module core_dispatcher
  import dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES      = DEF_NUM_CORES,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic               clock,
  input logic               reset_n,
  core_dispatcher_if.slave  bus
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_CORES-1:0]   mask_w, cdone_w, cdone_d_w;
  logic [2*NUM_CORES-1:0] status_w;
  logic                   launch, run, complete, abort;

  assign launch   = (state_q == S_IDLE) && bus.start;
  assign run      = (state_q == S_RUN);
  assign complete = run && (&(cdone_d_w | ~mask_w));

`ifdef DISPATCH_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  assign abort = run && !complete && ((wd_q + 32'd1) >= 32'(TIMEOUT_CYCLES));

  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (launch) begin
      wd_d      = '0;
      timeout_d = 1'b0;
    end else if (run) begin
      wd_d = wd_q + 32'd1;
      if (abort) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign abort       = 1'b0;
  assign bus.timeout = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d   = '0;
          state_d = (|bus.core_mask) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (complete || abort) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    dispatch_slot u_slot (
      .clock     (clock),
      .reset_n   (reset_n),
      .launch_i  (launch),
      .mask_i    (bus.core_mask[i]),
      .end_i     (bus.end_process[i]),
      .run_i     (run),
      .abort_i   (abort),
      .state_d_i (state_d),
      .mask_o    (mask_w[i]),
      .done_o    (cdone_w[i]),
      .done_d_o  (cdone_d_w[i]),
      .status_o  (status_w[2*i+1:2*i])
    );
  end

  assign bus.status      = status_w;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.core_done   = cdone_w;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// Directed + randomized bench for core_dispatcher against a job-level reference model.
module tb_core_dispatcher;
  import dispatch_pkg::*;

  localparam int unsigned NC = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned TO = 50;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  core_dispatcher_if #(.NUM_CORES(NC), .CNT_W(CW)) bus ();

  core_dispatcher #(.NUM_CORES(NC), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] stat(input logic [3:0] m, input logic [1:0] code);
    logic [7:0] r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[2*i +: 2] = code;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: masked core i is first seen at launch edge + max(d,1); job ends at the latest of these.
  task automatic run_job(input logic [3:0] mask, input int d[4], input int noise[4], input bit busy_start);
    int          fin;
    int          jd = 0;
    logic [3:0]  exp_cd;
    for (int i = 0; i < 4; i++) begin
      fin = (d[i] < 1) ? 1 : d[i];
      if (mask[i] && fin > jd) jd = fin;
      if (mask[i] && d[i] == 0) bus.end_process[i] = 1'b1;
      if (!mask[i] && noise[i] == 0) bus.end_process[i] = 1'b1;
    end
    bus.start = 1'b1;
    bus.core_mask = mask;
    tick();
    bus.start = 1'b0;
    bus.core_mask = 4'($urandom);
    check("launch_busy", bus.busy, 1);
    check("launch_done", bus.done, 0);
    check("launch_status", bus.status, stat(mask, ST_RUN));
    check("launch_count", bus.cycle_count, 0);
    for (int k = 1; k <= jd; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i] && d[i] <= k) bus.end_process[i] = 1'b1;
        if (!mask[i] && noise[i] <= k) bus.end_process[i] = 1'b1;
      end
      if (busy_start && k == 5) begin
        bus.start = 1'b1;
        bus.core_mask = 4'b1000;
      end
      tick();
      bus.start = 1'b0;
      exp_cd = '0;
      for (int i = 0; i < 4; i++) if (mask[i] && d[i] <= k) exp_cd[i] = 1'b1;
      if (k < jd) begin
        check("run_busy", bus.busy, 1);
        check("run_done", bus.done, 0);
        check("run_count", bus.cycle_count, k);
        check("run_core_done", bus.core_done, exp_cd);
        check("run_status", bus.status, stat(mask, ST_RUN));
      end else begin
        check("done_pulse", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_count", bus.cycle_count, jd);
        check("done_core_done", bus.core_done, mask);
        check("done_status", bus.status, stat(mask, ST_ACK));
        check("done_timeout", bus.timeout, 0);
      end
    end
    // A start coinciding with the done cycle must be dropped.
    bus.start = 1'b1;
    bus.core_mask = 4'($urandom_range(15, 1));
    tick();
    bus.start = 1'b0;
    check("post_done", bus.done, 0);
    check("post_busy", bus.busy, 0);
    check("post_status", bus.status, 0);
    check("post_core_done", bus.core_done, mask);
    check("post_count", bus.cycle_count, jd);
    bus.end_process = '0;
    tick();
  endtask

  initial begin
    int dd[4];
    int nn[4];
    logic [3:0] m;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.core_mask = '0;
    bus.end_process = '0;
    tick();
    tick();
    check("rst_status", bus.status, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_core_done", bus.core_done, 0);
    check("rst_count", bus.cycle_count, 0);
    check("rst_timeout", bus.timeout, 0);
    reset_n = 1'b1;
    tick();

    // Normal job with a rejected second start at cycle 5.
    run_job(4'b0101, '{10, 0, 25, 0}, '{99, 3, 99, 7}, 1'b1);

    // Empty mask: straight to done.
    bus.start = 1'b1;
    bus.core_mask = 4'b0000;
    tick();
    bus.start = 1'b0;
    check("empty_done", bus.done, 1);
    check("empty_busy", bus.busy, 0);
    check("empty_count", bus.cycle_count, 0);
    check("empty_status", bus.status, 0);
    tick();
    check("empty_done_clr", bus.done, 0);
    check("empty_busy2", bus.busy, 0);
    tick();

    // Pre-asserted finish.
    run_job(4'b0010, '{99, 0, 99, 99}, '{40, 40, 40, 40}, 1'b0);

    for (int j = 0; j < 8; j++) begin
      m = 4'($urandom_range(15, 1));
      for (int i = 0; i < 4; i++) begin
        dd[i] = $urandom_range(30, 0);
        nn[i] = $urandom_range(40, 0);
      end
      run_job(m, dd, nn, 1'($urandom));
    end

`ifdef DISPATCH_TIMEOUT_EN
    bus.start = 1'b1;
    bus.core_mask = 4'b0011;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= int'(TO); k++) begin
      if (k == 5) bus.end_process[0] = 1'b1;
      tick();
      if (k == int'(TO) - 1) begin
        check("wd_pre_done", bus.done, 0);
        check("wd_pre_timeout", bus.timeout, 0);
      end
    end
    check("wd_done", bus.done, 1);
    check("wd_timeout", bus.timeout, 1);
    check("wd_status", bus.status, 8'b0000_1110);
    check("wd_count", bus.cycle_count, TO);
    tick();
    check("wd_sticky", bus.timeout, 1);
    check("wd_status_clr", bus.status, 0);
    bus.end_process = '0;
    run_job(4'b0001, '{3, 99, 99, 99}, '{99, 99, 99, 99}, 1'b0);
`else
    bus.start = 1'b1;
    bus.core_mask = 4'b0011;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= int'(TO) + 10; k++) begin
      if (k == 5) bus.end_process[0] = 1'b1;
      tick();
      if (k % 10 == 0) check("nowd_done", bus.done, 0);
    end
    check("nowd_busy", bus.busy, 1);
    check("nowd_timeout", bus.timeout, 0);
    check("nowd_count", bus.cycle_count, TO + 10);
    bus.end_process = '0;
`endif

    // Asynchronous reset in the middle of a running job.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    bus.start = 1'b1;
    bus.core_mask = 4'b1111;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("mid_busy", bus.busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_status", bus.status, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_core_done", bus.core_done, 0);
    check("arst_count", bus.cycle_count, 0);
    check("arst_done", bus.done, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("arst_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_dispatcher.md
Name: core_dispatcher

Overview:
Initiator side of the per-core start/finish handshake. Launches up to NUM_CORES processor cores by driving each core's 2-bit status input, and collects each core's end_process flag. Reports a single job-done pulse and a run-cycle count to the top-level matrix-multiplication sequencer. Sits between the top-level sequencer and the core array.

Parameters:
NUM_CORES, 4, number of cores served; 1..16
CNT_W, 32, width of cycle_count
TIMEOUT_CYCLES, 100000, watchdog limit in RUN cycles; used only with DISPATCH_TIMEOUT_EN

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle job request from sequencer
core_mask  input  NUM_CORES  cores to launch; sampled on accepted start
end_process  input  NUM_CORES  per-core finish level, registered in core, held high once core ends
status  output  2*NUM_CORES  per-core command; core i uses bits [2i+1:2i]
busy  output  1  high while the job is in progress
done  output  1  one-cycle pulse at job completion
core_done  output  NUM_CORES  sticky per-core finished flags for the current job
cycle_count  output  CNT_W  RUN cycles of the last or current job
timeout  output  1  sticky watchdog flag; constant 0 without the feature

Behaviour:
- Status encoding: 00 IDLE, 01 RUN, 10 ACK (job complete), 11 ABORT. A core leaves its idle state only on 01; other codes are ignored.
- Reset (asynchronous, reset_n=0) forces:
  - FSM to S_IDLE
  - status all 00; busy, done, timeout = 0
  - core_done = 0; cycle_count = 0
- FSM states: S_IDLE, S_RUN, S_DONE. Registered outputs only.
- S_IDLE:
  - start=1 with core_mask!=0: latch mask, clear core_done/cycle_count/timeout, go to S_RUN.
  - start=1 with core_mask==0: go directly to S_DONE; cycle_count=0.
  - start=0: stay.
- S_RUN:
  - status=01 for masked cores, 00 for others; busy=1.
  - cycle_count increments each cycle and saturates at all-ones.
  - core_done[i] |= end_process[i] & mask[i]. Unmasked end_process is ignored.
  - Leave for S_DONE on the cycle where (core_done | incoming masked end_process) covers the full mask.
- Latency: status=01 appears the cycle after the start edge. done asserts the cycle after the last masked end_process is first seen high.
- S_DONE:
  - done=1 for exactly one cycle; status=10 for masked cores; busy=0.
  - Next state S_IDLE; status returns to 00 and core_done holds until the next start.
- Edge cases:
  - start while busy is ignored (no queueing).
  - start in the same cycle as done is also ignored.
  - end_process already high at launch counts as finished on the first S_RUN cycle.
  - reset mid-job aborts immediately; all outputs take their reset values.

Optional Feature:
DISPATCH_TIMEOUT_EN
- Defined:
  - If S_RUN reaches TIMEOUT_CYCLES without completion, set timeout=1 (sticky until the next accepted start).
  - Drive status=11 to unfinished masked cores and 10 to finished ones for the S_DONE cycle, then pulse done.
- Undefined:
  - No watchdog; S_RUN waits indefinitely; timeout tied to 0.

Decomposition:
- Package dispatch_pkg:
  - status code constants ST_IDLE/ST_RUN/ST_ACK/ST_ABORT
  - FSM state typedef (2-bit)
  - default NUM_CORES
- One sub-module, dispatch_slot, instanced per core:
  - holds the mask bit and sticky done bit
  - drives that core's 2-bit status from the FSM state and the timeout flag

Test Plan:
- Reset: reset_n low mid-S_RUN with mask=4'b1111 -> status=0, busy=0, core_done=0, cycle_count=0 immediately (asynchronous).
- Normal job: mask=4'b0101, cores 0 and 2 raise end_process 10 and 25 cycles after launch -> done pulses once, 1 cycle after core 2 rises; cycle_count=25; core_done=4'b0101; status cores 0/2 = 10 during the done cycle, then 00.
- Empty mask: start with mask=0 -> done pulses the next cycle, busy never high, cycle_count=0.
- Busy protection: second start 5 cycles into a job with mask=4'b1000 -> ignored; the original mask completes, and cores 0–2 status stays as launched.
- Pre-asserted finish: end_process[1]=1 before start, mask=4'b0010 -> done 2 cycles after the start edge; cycle_count=1.
- With DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=50: mask=4'b0011, only core 0 finishes -> after 50 RUN cycles, status core1=11, core0=10, timeout=1, done pulse; without the macro -> no done and busy stays high.
